// File: rtl/observer_pkg.sv
// Shared types and constants for the ObserverComb stimulus sequencer and its
// signature compactor.
package observer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      SWEEP = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [15:0] MISR_TAP  = 16'hD008;
   localparam int          CODE_W    = 4;
   localparam int          POST_MULT = 2;

   // Taps at bits 15/14/12/3; the three observer responses fold into the low bits.
   function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [2:0] d);
      logic fb;
      fb = ^(s & MISR_TAP);
      return {s[14:0], fb} ^ {13'b0, d};
   endfunction

endpackage

// File: rtl/observer_misr.sv
// 16-bit multiple-input signature register compacting {Out2, Out1, Out0Mux}.
module observer_misr
   import observer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        en,
   input  logic [2:0]  data,
   output logic [15:0] sig
);

   logic [15:0] sig_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if (clear) begin
         sig_q <= '0;
      end else if (en) begin
         sig_q <= misr_next(sig_q, data);
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/observer_stim_seq.sv
// Drives Enable/In0..In3 of an ObserverComb instance through a pre-phase and a
// full 16-code sweep, compacting its responses and checking the signature.
module observer_stim_seq
   import observer_pkg::*;
#(
   parameter int HOLD_CYCLES = 5,
   parameter int SIG_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [SIG_W-1:0] expected_sig,
   input  logic             Out0Mux,
   input  logic             Out1,
   input  logic             Out2,
   output logic             Enable,
   output logic             In0,
   output logic             In1,
   output logic             In2,
   output logic             In3,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature,
   output logic             pass
);

   localparam int CNT_W = $clog2(POST_MULT * HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  POST_LD  = CNT_W'(POST_MULT * HOLD_CYCLES - 1);
   localparam logic [CODE_W-1:0] CODE_MAX = '1;

   state_e             state_q, state_d;
   logic               enable_q, enable_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               misr_clr, misr_en;
   logic               step_end;
   logic [SIG_W-1:0]   sig_w;

   assign step_end = (cnt_q == '0);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d  = state_q;
      enable_d = enable_q;
      code_d   = code_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      cnt_d    = cnt_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = PRE;
               busy_d   = 1'b1;
               enable_d = 1'b0;
               code_d   = '0;
               pass_d   = 1'b0;
               cnt_d    = HOLD_LD;
               misr_clr = 1'b1;
            end
         end
         PRE: begin
            if (step_end) begin
               state_d  = SWEEP;
               enable_d = 1'b1;
               code_d   = '0;
               cnt_d    = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SWEEP: begin
            if (step_end) begin
               // The last cycle of each hold samples the settled observer response.
               misr_en = 1'b1;
               if (code_q == CODE_MAX) begin
                  state_d = POST;
                  cnt_d   = POST_LD;
               end else begin
                  code_d = code_q + 1'b1;
                  cnt_d  = HOLD_LD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         POST: begin
            if (step_end) begin
               state_d  = DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               pass_d   = (sig_w == expected_sig);
               enable_d = 1'b0;
               code_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
      if (!rst_n) begin
         state_q  <= IDLE;
         enable_q <= 1'b0;
         code_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
         code_q   <= code_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         cnt_q    <= cnt_d;
      end
   end

   observer_misr u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (misr_clr),
      .en    (misr_en),
      .data  ({Out2, Out1, Out0Mux}),
      .sig   (sig_w)
   );

   assign Enable    = enable_q;
   assign {In0, In1, In2, In3} = code_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_w;

endmodule

// File: tb/tb_observer_stim_seq.sv
// Directed bench: default-timing instance plus a HOLD_CYCLES=1 instance, with an
// optional observer stub wired back from the stimulus outputs.
module tb_observer_stim_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n0, rst_n1, start0, start1, stub_en, sel;
   logic [15:0] exp0, exp1;
   logic        en0, a0, b0, c0, d0, busy0, done0, pass0;
   logic        en1, a1, b1, c1, d1, busy1, done1, pass1;
   logic [15:0] sig0, sig1;
   logic        o0_0, o1_0, o2_0, o0_1, o1_1, o2_1;

   int errors = 0;
   int checks = 0;
   int done_cnt0 = 0;
   int done_cnt1 = 0;
   logic [15:0] model_sig;

   // Observer stub: Out0Mux=In3, Out1=In2, Out2=In0.
   assign o0_0 = stub_en & d0;
   assign o1_0 = stub_en & c0;
   assign o2_0 = stub_en & a0;
   assign o0_1 = stub_en & d1;
   assign o1_1 = stub_en & c1;
   assign o2_1 = stub_en & a1;

   observer_stim_seq #(.HOLD_CYCLES(5)) dut0 (
      .clk(clk), .rst_n(rst_n0), .start(start0), .expected_sig(exp0),
      .Out0Mux(o0_0), .Out1(o1_0), .Out2(o2_0),
      .Enable(en0), .In0(a0), .In1(b0), .In2(c0), .In3(d0),
      .busy(busy0), .done(done0), .signature(sig0), .pass(pass0)
   );

   observer_stim_seq #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n1), .start(start1), .expected_sig(exp1),
      .Out0Mux(o0_1), .Out1(o1_1), .Out2(o2_1),
      .Enable(en1), .In0(a1), .In1(b1), .In2(c1), .In3(d1),
      .busy(busy1), .done(done1), .signature(sig1), .pass(pass1)
   );

   logic       mon_busy, mon_done, mon_en;
   logic [3:0] mon_code;
   assign mon_busy = sel ? busy1 : busy0;
   assign mon_done = sel ? done1 : done0;
   assign mon_en   = sel ? en1 : en0;
   assign mon_code = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};

   always @(negedge clk) begin
      if (done0 === 1'b1) done_cnt0++;
      if (done1 === 1'b1) done_cnt1++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called right after the accepting edge (n=0); walks to n=last_n.
   task automatic check_run(input int h, input int last_n);
      logic [3:0] exp_code;
      for (int n = 0; n <= last_n; n++) begin
         check($sformatf("busy_done n=%0d", n), {30'd0, mon_busy, mon_done},
               {30'd0, 1'(n < 19 * h), 1'(n == 19 * h)});
         if (n < 19 * h) begin
            if (n < h)           exp_code = 4'd0;
            else if (n < 17 * h) exp_code = 4'((n - h) / h);
            else                 exp_code = 4'd15;
            check($sformatf("en_code n=%0d", n), {27'd0, mon_en, mon_code},
                  {27'd0, 1'(n >= h), exp_code});
         end
         if (n < last_n) step();
      end
   endtask

   initial begin
      logic [15:0] s;
      logic [3:0]  c;
      s = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         c = 4'(i);
         s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {13'b0, c[3], c[1], c[0]};
      end
      model_sig = s;

      rst_n0 = 1'b0; rst_n1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
      stub_en = 1'b0; sel = 1'b0; exp0 = 16'h0000; exp1 = 16'h0000;

      // Reset and idle
      repeat (3) step();
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("idle0", {en0, a0, b0, c0, d0, busy0, done0, pass0, sig0}, 32'd0);
         check("idle1", {en1, a1, b1, c1, d1, busy1, done1, pass1, sig1}, 32'd0);
         step();
      end

      // Default timing, responses tied low
      done_cnt0 = 0;
      start0 = 1'b1; step(); start0 = 1'b0;
      check_run(5, 96);
      check("zero_sig", {16'd0, sig0}, 32'h0000);
      check("zero_pass", {31'd0, pass0}, 32'd1);
      check("zero_done_cnt", done_cnt0, 1);

      // Stubbed observer, golden off by one bit
      stub_en = 1'b1; exp0 = model_sig ^ 16'h0001;
      start0 = 1'b1; step(); start0 = 1'b0;
      check_run(5, 96);
      check("stub_sig", {16'd0, sig0}, {16'd0, model_sig});
      check("stub_pass_bad", {31'd0, pass0}, 32'd0);
      repeat (5) step();
      check("sig_persist", {16'd0, sig0}, {16'd0, model_sig});

      // start held high through the whole run and the DONE cycle
      exp0 = model_sig; done_cnt0 = 0;
      start0 = 1'b1; step();
      check_run(5, 96);
      check("held_pass", {31'd0, pass0}, 32'd1);
      step();
      check("rerun_busy", {31'd0, busy0}, 32'd1);
      check("rerun_clear", {15'd0, en0, sig0}, 32'd0);
      check("held_done_cnt", done_cnt0, 1);
      start0 = 1'b0;

      // Reset during SWEEP at code 7
      repeat (40) step();
      check("pre_rst_code", {27'd0, en0, a0, b0, c0, d0}, {27'd0, 1'b1, 4'd7});
      done_cnt0 = 0;
      rst_n0 = 1'b0; step(); rst_n0 = 1'b1;
      check("mid_rst", {en0, a0, b0, c0, d0, busy0, done0, pass0, sig0}, 32'd0);
      repeat (120) step();
      check("mid_rst_no_done", done_cnt0, 0);
      check("mid_rst_idle", {31'd0, busy0}, 32'd0);

      // HOLD_CYCLES=1 instance
      sel = 1'b1; exp1 = model_sig; done_cnt1 = 0;
      start1 = 1'b1; step(); start1 = 1'b0;
      check_run(1, 20);
      check("h1_sig", {16'd0, sig1}, {16'd0, model_sig});
      check("h1_pass", {31'd0, pass1}, 32'd1);
      check("h1_done_cnt", done_cnt1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/observer_stim_seq.md
Name: observer_stim_seq

Overview:
Synthesizable driver for the ObserverComb interface, on the side that produces Enable and In0..In3 and consumes Out0Mux/Out1/Out2. On a start pulse it holds Enable low for a pre-phase, then raises Enable and sweeps all 16 input codes. While sweeping, it compacts the observer responses into a 16-bit MISR signature and compares that signature against an expected value. The block is the on-chip replacement for a simulation-only stimulus sequence and sits next to the ObserverComb instance.

Parameters:
HOLD_CYCLES, 5, clock cycles each phase step is held; legal range is 1 or more.
SIG_W, 16, signature width; fixed at 16 for this revision.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
start  in  1  request a run; honoured only in IDLE.
expected_sig  in  16  golden signature; sampled when the run ends.
Out0Mux  in  1  observer response.
Out1  in  1  observer response.
Out2  in  1  observer response.
Enable  out  1  observer enable (registered).
In0  out  1  stimulus bit, MSB of the sweep code (registered).
In1  out  1  stimulus bit (registered).
In2  out  1  stimulus bit (registered).
In3  out  1  stimulus bit, LSB of the sweep code (registered).
busy  out  1  high from the start acceptance through the end of POST.
done  out  1  one-cycle pulse at the end of a run.
signature  out  16  MISR contents.
pass  out  1  1 when signature equals expected_sig; valid from done onward.

Behaviour:
- Reset (rst_n low at an edge): state IDLE; Enable, In0..In3, busy, done and pass are 0; signature is 0x0000; the hold counter is 0. Reset has priority over every other event, including mid-run; the next edge after rst_n rises behaves as IDLE.
- Sweep code: code[3:0] = {In0,In1,In2,In3}.
- FSM states and transitions:
  - IDLE: if start is high at edge k, then after edge k the state is PRE, busy=1, Enable=0, code=0, signature cleared to 0, pass=0.
  - PRE: lasts HOLD_CYCLES cycles. On exit, Enable=1, code=0, state SWEEP.
  - SWEEP: each code is held HOLD_CYCLES cycles.
    - On the final cycle of each hold, the edge updates the MISR with the current Out2/Out1/Out0Mux.
    - At that same edge, code increments, except after code 15.
    - After code 15, state goes to POST and code stays 15.
  - POST: lasts 2*HOLD_CYCLES cycles with Enable=1 and code=15. The exit edge sets busy=0, done=1, pass=(signature==expected_sig), state DONE.
  - DONE: one cycle. done returns to 0 and the state returns to IDLE. start is ignored in this state.
- Run length: busy is high for exactly 19*HOLD_CYCLES cycles (95 at the default). done follows immediately after.
- MISR update:
  - fb = s[15]^s[14]^s[12]^s[3].
  - s_next = {s[14:0],fb} ^ {13'b0,Out2,Out1,Out0Mux}.
  - Exactly 16 updates occur per run.
- Hold counter: width $clog2(2*HOLD_CYCLES+1). It reloads at every phase or step change and never wraps mid-step.
- start while busy, or in DONE, is ignored with no side effect.
- signature and pass persist after the run until the next accepted start.
- expected_sig is sampled only at the POST exit edge.

Decomposition:
- Shared package observer_pkg holds:
  - the state enum: IDLE, PRE, SWEEP, POST, DONE
  - MISR tap constant 16'hD008
  - code width constant 4
  - POST multiplier constant 2
- One sub-module, observer_misr: inputs clk, rst_n, clear, en, data[2:0]; output sig[15:0]. It is instantiated once.

Test Plan:
- Reset and idle: hold rst_n low 3 cycles, then release with start=0 → all outputs 0 and signature 0x0000 for 20 cycles.
- Default timing: start pulse at edge k, outputs tied to 0.
  - Enable rises after edge k+5.
  - code steps 0→15 every 5 cycles.
  - busy is high for 95 cycles and done pulses once at the following cycle.
  - signature = 0x0000; with expected_sig=0x0000, pass=1.
- Signature check: stub Out0Mux=In3, Out1=In2, Out2=In0 → signature equals the bench MISR model. With expected_sig set to model^0x0001, pass=0.
- start re-assertion: start held high throughout a run, including the DONE cycle → a single run only, and busy drops for at least 1 cycle before the next run begins.
- Reset mid-run: rst_n low for one edge during SWEEP at code 7 → next cycle Enable=0, code=0, busy=0, signature=0x0000, done never pulses.
- HOLD_CYCLES=1: start → busy for 19 cycles, code changes every cycle, 16 MISR updates, done pulses at cycle 20.
